// File: rtl/sop_seq_ctrl.sv
// 4-tap sum-of-products sequencer on one shared MAC; result valid 4 clocks after accept, held until out_ready.
// No new sample is taken while a result is pending. Optional `flush` port for the delay line: SOP_SEQ_FLUSH_EN.
module sop_seq_ctrl #(
   parameter int width = 4
) (
   input  logic                 CLK,
   input  logic                 RESET,
`ifdef SOP_SEQ_FLUSH_EN
   input  logic                 flush,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [width-1:0]     data_in,
   input  logic                 cfg_we,
   input  logic [1:0]           cfg_addr,
   input  logic [width:0]       cfg_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*width+2:0]   out_data,
   output logic                 busy
);

   localparam int W_P = 2*width + 1;
   localparam int W_A = 2*width + 3;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       r_tap;
   logic [W_A-1:0]   r_acc;
   logic [W_A-1:0]   r_out_data;
   logic             r_out_valid;
   logic [width-1:0] r_x [4];
   logic [width:0]   r_c [4];

   logic             w_idle;
   logic             w_flush;
   logic             w_do_flush;
   logic             w_cfg_wr;
   logic             w_accept;
   logic [W_P-1:0]   w_prod;
   logic [W_A-1:0]   w_sum;

   always_comb begin
      w_idle = (r_state == S_IDLE);
`ifdef SOP_SEQ_FLUSH_EN
      w_flush = flush;
`else
      w_flush = 1'b0;
`endif
      w_do_flush = w_idle && w_flush;
      w_cfg_wr   = w_idle && cfg_we;
      in_ready   = w_idle && !cfg_we && !w_flush;
      w_accept   = in_valid && in_ready;
      w_prod     = W_P'(r_c[r_tap]) * W_P'(r_x[r_tap]);
      w_sum      = r_acc + W_A'(w_prod);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state     <= S_IDLE;
         r_tap       <= 2'd0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_x[i] <= '0;
            r_c[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cfg_wr) begin
                  r_c[cfg_addr] <= cfg_data;
               end
               // flush outranks a sample; in_ready is already low then, so this is only a safeguard
               if (w_do_flush) begin
                  for (int i = 0; i < 4; i++) begin
                     r_x[i] <= '0;
                  end
               end else if (w_accept) begin
                  r_x[3]  <= r_x[2];
                  r_x[2]  <= r_x[1];
                  r_x[1]  <= r_x[0];
                  r_x[0]  <= data_in;
                  r_acc   <= '0;
                  r_tap   <= 2'd0;
                  r_state <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= w_sum;
               r_tap <= r_tap + 2'd1;
               if (r_tap == 2'd3) begin
                  r_out_data  <= w_sum;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sop_seq_ctrl.sv
// Directed bench for sop_seq_ctrl: stimulus pushes expected results, a negedge monitor pops and checks them.
module tb_sop_seq_ctrl;

   localparam int WD = 4;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              in_valid;
   logic              in_ready;
   logic [WD-1:0]     data_in;
   logic              cfg_we;
   logic [1:0]        cfg_addr;
   logic [WD:0]       cfg_data;
   logic              out_valid;
   logic              out_ready;
   logic [2*WD+2:0]   out_data;
   logic              busy;
`ifdef SOP_SEQ_FLUSH_EN
   logic              flush;
`endif

   sop_seq_ctrl #(.width(WD)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
`ifdef SOP_SEQ_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   int     cyc = 0;
   int     n_tests = 0;
   int     n_fail = 0;
   longint exp_q[$];
   int     acc_q[$];
   logic   prev_vld = 1'b0;

   always @(posedge CLK) cyc++;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: accept edges are recorded to measure latency; every output handshake pops one expected result.
   always @(negedge CLK) begin
      if (!RESET) begin
         acc_q.delete();
         prev_vld = 1'b0;
      end else begin
         if (in_valid && in_ready) acc_q.push_back(cyc + 1);
         if (out_valid && !prev_vld) begin
            if (acc_q.size() == 0) chk("latency accept record", 0, 1);
            else chk("latency", longint'(cyc - acc_q.pop_front()), 4);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected output", longint'(out_data), -1);
            else chk("result", longint'(out_data), exp_q.pop_front());
         end
         prev_vld = out_valid;
      end
   end

   task automatic wcfg(input int a, input int d);
      cfg_we   = 1'b1;
      cfg_addr = 2'(a);
      cfg_data = 5'(d);
      @(posedge CLK);
      #1 cfg_we = 1'b0;
   endtask

   task automatic send(input int x, input bit push, input longint e, output int ae);
      bit ok;
      ok = 1'b0;
      ae = 0;
      if (push) exp_q.push_back(e);
      in_valid = 1'b1;
      data_in  = 4'(x);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge CLK);
         if (in_ready) begin
            ae = cyc + 1;
            ok = 1'b1;
         end
      end
      if (!ok) chk("accept timeout", 0, 1);
      @(posedge CLK);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge CLK);
         if (!busy && !out_valid) ok = 1'b1;
      end
      if (!ok) chk("idle timeout", 0, 1);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, e1, e2, e3, dummy;
      bit ok;
      RESET = 1'b1; in_valid = 1'b0; data_in = '0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
`ifdef SOP_SEQ_FLUSH_EN
      flush = 1'b0;
`endif
      #2 RESET = 1'b0;
      #1;
      chk("reset out_valid", longint'(out_valid), 0);
      chk("reset out_data", longint'(out_data), 0);
      chk("reset busy", longint'(busy), 0);
      chk("reset in_ready", longint'(in_ready), 1);
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b1;

      // c = 1,2,3,4; samples 1..4 back to back
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 5'd1;
      @(negedge CLK);
      chk("in_ready low under cfg_we", longint'(in_ready), 0);
      @(posedge CLK);
      #1 cfg_we = 1'b0;
      wcfg(1, 2); wcfg(2, 3); wcfg(3, 4);
      send(1, 1'b1, 1, e0);
      send(2, 1'b1, 4, e1);
      send(3, 1'b1, 10, e2);
      send(4, 1'b1, 20, e3);
      chk("accept spacing 1", longint'(e1 - e0), 6);
      chk("accept spacing 2", longint'(e2 - e1), 6);
      chk("accept spacing 3", longint'(e3 - e2), 6);
      wait_idle();

      // full-scale coefficients, line goes 4,3,2,1 -> all 15
      for (int i = 0; i < 4; i++) wcfg(i, 31);
      send(15, 1'b1, 744, dummy);
      send(15, 1'b1, 1147, dummy);
      send(15, 1'b1, 1519, dummy);
      send(15, 1'b1, 1860, dummy);
      wait_idle();

      // backpressure: line 0,15,15,15 -> 31*45
      out_ready = 1'b0;
      send(0, 1'b1, 1395, dummy);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge CLK);
         if (out_valid) ok = 1'b1;
      end
      if (!ok) chk("out_valid timeout", 0, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("stall out_data", longint'(out_data), 1395);
         chk("stall in_ready", longint'(in_ready), 0);
         chk("stall busy", longint'(busy), 1);
      end
      @(posedge CLK);
      #1 out_ready = 1'b1;
      wait_idle();
      chk("idle after stall", longint'(busy), 0);

      // write during busy is dropped; cfg_we beats in_valid in IDLE
      for (int i = 0; i < 4; i++) wcfg(i, i + 1);
      send(1, 1'b1, 106, dummy);
      wcfg(0, 7);
      wait_idle();
      send(2, 1'b1, 64, dummy);
      wait_idle();
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 5'd5; in_valid = 1'b1; data_in = 4'd9;
      @(negedge CLK);
      chk("in_ready with cfg_we+in_valid", longint'(in_ready), 0);
      @(posedge CLK);
      #1 cfg_we = 1'b0; in_valid = 1'b0;
      @(negedge CLK);
      chk("sample not accepted", longint'(busy), 0);
      @(posedge CLK);
      #1;
      send(3, 1'b1, 12, dummy);
      wait_idle();

      // reset during tap 2 discards the result
      send(1, 1'b0, 0, dummy);
      @(posedge CLK);
      @(posedge CLK);
      #1 RESET = 1'b0;
      #1;
      chk("midmac reset out_valid", longint'(out_valid), 0);
      chk("midmac reset out_data", longint'(out_data), 0);
      chk("midmac reset busy", longint'(busy), 0);
      chk("midmac reset in_ready", longint'(in_ready), 1);
      @(negedge CLK);
      @(posedge CLK);
      #1 RESET = 1'b1;
      for (int i = 0; i < 4; i++) wcfg(i, i + 1);
      send(5, 1'b1, 5, dummy);
      wait_idle();

`ifdef SOP_SEQ_FLUSH_EN
      // line 5,0,0,0 -> 1,2,3 then flush then 4
      send(1, 1'b1, 11, dummy);
      send(2, 1'b1, 19, dummy);
      send(3, 1'b1, 30, dummy);
      wait_idle();
      flush = 1'b1;
      @(negedge CLK);
      chk("in_ready low under flush", longint'(in_ready), 0);
      @(posedge CLK);
      #1 flush = 1'b0;
      send(4, 1'b1, 4, dummy);
      wait_idle();
`endif

      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge CLK);
         if (exp_q.size() == 0) ok = 1'b1;
      end
      chk("scoreboard drained", longint'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
